// File: rtl/negedge_sr_dff.sv
// Falling-edge D register with async active-low clear/preset, clock enable and qbar = ~q.
// Optional DFF_SR_CONFLICT_FLAG_EN adds the sr_conflict output and a dual-assert warning.
module negedge_sr_dff #(
  parameter int unsigned WIDTH = 1
) (
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  input  logic             clk,
  input  logic [WIDTH-1:0] d,
  input  logic             reset_n,
  input  logic             set_n,
  input  logic             ce
`ifdef DFF_SR_CONFLICT_FLAG_EN
  ,
  output logic             sr_conflict
`endif
);

  // Preset is masked by clear, so it falls when set_n drops with reset_n high
  // and also when reset_n releases while set_n is still low.
  logic set_active_n;
  assign set_active_n = set_n | ~reset_n;

  always_ff @(negedge clk or negedge reset_n or negedge set_active_n) begin
    if (!reset_n) begin
      q <= '0;
    end else if (!set_active_n) begin
      q <= '1;
    end else if (ce) begin
      q <= d;
    end
  end

  assign qbar = ~q;

`ifdef DFF_SR_CONFLICT_FLAG_EN
  assign sr_conflict = ~reset_n & ~set_n;

`ifndef SYNTHESIS
  always_comb begin
    assert (reset_n || set_n)
      else $warning("negedge_sr_dff: reset_n and set_n both asserted, clear dominates");
  end
`endif
`endif

endmodule

// File: tb/tb_negedge_sr_dff.sv
// Directed bench for negedge_sr_dff: single-bit instance plus an 8-bit instance.
module tb_negedge_sr_dff;

  logic       clk = 1'b0;
  logic       d, reset_n, set_n, ce;
  logic       q, qbar;
  logic [7:0] d8, q8, qbar8;
  logic       reset8_n, set8_n, ce8;
  int         total = 0;
  int         bad = 0;
`ifdef DFF_SR_CONFLICT_FLAG_EN
  logic       sr_conflict, sr_conflict8;
`endif

  always #5 clk = ~clk;

  negedge_sr_dff dut (
    .q(q), .qbar(qbar), .clk(clk), .d(d),
    .reset_n(reset_n), .set_n(set_n), .ce(ce)
`ifdef DFF_SR_CONFLICT_FLAG_EN
    , .sr_conflict(sr_conflict)
`endif
  );

  negedge_sr_dff #(.WIDTH(8)) dut8 (
    .q(q8), .qbar(qbar8), .clk(clk), .d(d8),
    .reset_n(reset8_n), .set_n(set8_n), .ce(ce8)
`ifdef DFF_SR_CONFLICT_FLAG_EN
    , .sr_conflict(sr_conflict8)
`endif
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b1; set_n = 1'b1; ce = 1'b1; d = 1'b0;
    reset8_n = 1'b1; set8_n = 1'b1; ce8 = 1'b0; d8 = 8'h00;
    #2;
    reset_n = 1'b0; reset8_n = 1'b0;
    #1;
    check("reset_q", {7'd0, q}, 8'h00);
    check("reset_qbar", {7'd0, qbar}, 8'h01);
    check("reset_q8", q8, 8'h00);
    reset_n = 1'b1; reset8_n = 1'b1;
    #1;
    check("reset_release_hold", {7'd0, q}, 8'h00);

    // Load: d changes mid-high phase
    @(posedge clk); #2 d = 1'b0;
    @(negedge clk); #1;
    check("load0_q", {7'd0, q}, 8'h00);
    check("load0_qbar", {7'd0, qbar}, 8'h01);
    @(posedge clk); #1 d = 1'b1;
    #1 check("rise_no_change0", {7'd0, q}, 8'h00);
    @(negedge clk); #1;
    check("load1_q", {7'd0, q}, 8'h01);
    check("load1_qbar", {7'd0, qbar}, 8'h00);
    @(posedge clk); #1;
    check("rise_no_change1", {7'd0, q}, 8'h01);

    // Async clear between edges
    #1 reset_n = 1'b0;
    #1;
    check("clr_q", {7'd0, q}, 8'h00);
    check("clr_qbar", {7'd0, qbar}, 8'h01);
    #1 reset_n = 1'b1;
    #1 check("clr_release_hold", {7'd0, q}, 8'h00);
    @(negedge clk); #1;
    check("clr_reload1", {7'd0, q}, 8'h01);

    // Async preset between edges
    d = 1'b0;
    @(negedge clk); #1;
    check("pre_setup0", {7'd0, q}, 8'h00);
    #1 set_n = 1'b0;
    #1;
    check("pre_q", {7'd0, q}, 8'h01);
    check("pre_qbar", {7'd0, qbar}, 8'h00);
    #1 set_n = 1'b1;
    #1 check("pre_release_hold", {7'd0, q}, 8'h01);
    @(negedge clk); #1;
    check("pre_reload0", {7'd0, q}, 8'h00);

    // Clock enable
    d = 1'b1;
    @(negedge clk); #1;
    check("ce_setup1", {7'd0, q}, 8'h01);
    ce = 1'b0; d = 1'b0;
    repeat (2) @(negedge clk);
    #1 check("ce_hold", {7'd0, q}, 8'h01);
    ce = 1'b1;
    @(negedge clk); #1;
    check("ce_load0", {7'd0, q}, 8'h00);

    // Dual assert: clear dominates, d toggling is ignored
    d = 1'b1;
    @(negedge clk); #1;
    check("dual_setup1", {7'd0, q}, 8'h01);
    reset_n = 1'b0; set_n = 1'b0;
    #1;
    check("dual_q", {7'd0, q}, 8'h00);
    check("dual_qbar", {7'd0, qbar}, 8'h01);
`ifdef DFF_SR_CONFLICT_FLAG_EN
    check("dual_conflict", {7'd0, sr_conflict}, 8'h01);
`endif
    repeat (2) begin
      @(negedge clk); #1 d = ~d;
      check("dual_hold_q", {7'd0, q}, 8'h00);
      check("dual_hold_qbar", {7'd0, qbar}, 8'h01);
    end
    // Clear releases first with preset still low: preset takes over
    reset_n = 1'b1;
    #1 check("dual_set_takeover", {7'd0, q}, 8'h01);
`ifdef DFF_SR_CONFLICT_FLAG_EN
    check("conflict_clear", {7'd0, sr_conflict}, 8'h00);
`endif
    set_n = 1'b1;
    #1 check("dual_set_release_hold", {7'd0, q}, 8'h01);
    d = 1'b0;
    @(negedge clk); #1;
    check("dual_reload0", {7'd0, q}, 8'h00);

    // Both asserted then released together
    reset_n = 1'b0; set_n = 1'b0;
    #1 d = 1'b1;
    @(negedge clk); #1;
    check("dual2_q", {7'd0, q}, 8'h00);
    set_n = 1'b1; reset_n = 1'b1;
    #1 check("dual2_release_hold", {7'd0, q}, 8'h00);
    @(negedge clk); #1;
    check("dual2_reload1", {7'd0, q}, 8'h01);

    // WIDTH=8
    d8 = 8'hA5; ce8 = 1'b1;
    @(negedge clk); #1;
    check("w8_load_q", q8, 8'hA5);
    check("w8_load_qbar", qbar8, 8'h5A);
    #1 set8_n = 1'b0;
    #1 check("w8_pre_q", q8, 8'hFF);
    check("w8_pre_qbar", qbar8, 8'h00);
    #1 reset8_n = 1'b0;
    #1 check("w8_clr_q", q8, 8'h00);
    check("w8_clr_qbar", qbar8, 8'hFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/negedge_sr_dff.md
Name: negedge_sr_dff

Overview:
- Falling-edge-triggered D register with asynchronous active-low clear and preset, clock enable, and complementary outputs.
- Generic storage/synchronisation leaf cell, used wherever a negedge-sampled bit or bus is needed, e.g. half-cycle retiming or capture on the opposite clock phase.
- Width-parameterised; default is a single-bit flip-flop.

Parameters:
- WIDTH, 1, data width of d/q/qbar in bits (legal range 1..64).

Ports:
- clk  input  1  single clock; data is sampled on the falling edge only.
- reset_n  input  1  asynchronous, active-low clear; forces q to all zeros.
- set_n  input  1  asynchronous, active-low preset; forces q to all ones.
- ce  input  1  clock enable; a falling edge loads d only when ce=1.
- d  input  WIDTH  data in.
- q  output  WIDTH  registered data.
- qbar  output  WIDTH  bitwise complement of q.
- Positional declaration order is fixed for existing instantiations: q, qbar, clk, d, reset_n, set_n, ce.

Behaviour:
- Interface (already decided): one clock; reset is asynchronous and active-low.
- Priority, highest first:
  1. reset_n=0 -> q = 0.
  2. set_n=0 -> q = all ones.
  3. Falling edge of clk with ce=1 -> q <= d.
  4. Otherwise q holds.
- Clear and preset are asynchronous:
  - q changes as soon as the asserting edge of reset_n/set_n arrives, with no clock needed.
  - q stays forced while the signal is held low, regardless of clk, ce or d.
- Simultaneous clear and preset (both low) -> reset dominates: q=0, qbar=all ones. This is a legal, deterministic state, not X.
- Release of reset_n/set_n:
  - q keeps its forced value until the next qualifying falling clk edge. There is no synchronous re-load on release.
  - If reset releases while set_n is still low, q goes to all ones immediately.
- Latency: d is visible on q immediately after the falling clk edge at which it is sampled (one edge, zero additional delay).
- Rising clk edges never change q.
- ce=0: d is ignored and q holds indefinitely.
- qbar is always exactly ~q, including during reset, preset and the dual-assert case. It is never driven from independent logic.
- Power-up state before any reset or clock edge is undefined. Users must assert reset_n or set_n, or clock in data, before relying on q.
- No internal state other than q; no X-propagation sanitising of d.

Optional Feature:
- Macro: DFF_SR_CONFLICT_FLAG_EN.
- Defined:
  - Adds output port sr_conflict (1 bit), appended after ce.
  - sr_conflict is 1 combinationally whenever reset_n=0 and set_n=0, else 0.
  - Adds a simulation-only assertion that warns on this condition.
  - Storage behaviour is unchanged (reset still dominates).
- Undefined: port and assertion are absent; the port list is exactly the seven ports above.

Test Plan:
- Load: reset_n=1, set_n=1, ce=1; d=0 then d=1, changing d mid-high-phase of clk -> q=0/qbar=1 after the first falling edge, then q=1/qbar=0 after the next. Rising edges produce no change.
- Async clear: with q=1, pulse reset_n=0 between clock edges -> q=0, qbar=1 immediately. After release, q stays 0 until a falling edge with ce=1 and d=1, then q=1.
- Async preset: with q=0, pulse set_n=0 between edges -> q=1, qbar=0 immediately. It holds 1 after release until a falling edge samples d=0.
- Clock enable: q=1, ce=0, d=0 for 2 full clock periods -> q stays 1. Set ce=1 -> q=0 after the next falling edge.
- Dual assert: reset_n=0 and set_n=0 together for 2 periods while d toggles -> q=0, qbar=1 throughout, and sr_conflict=1 if the macro is defined. Then release both, set d=1, ce=1 -> q=1 after the next falling edge.
- WIDTH=8: d=8'hA5, clock it in, then set_n=0 -> q goes 8'hA5 then 8'hFF. Then reset_n=0 -> q=8'h00, qbar=8'hFF.
